rmc_req_arbiter: RTL and testbench

Shares the CPU's single remote-memory-controller request/response channel between NUM_REQ host requesters. It sits between the host ports and the CPU's request FIFO (write side) and read FIFO (read side). Requests are granted round-robin into the request FIFO. The originating requester index is recorded in an in-order tag queue, so each word the CPU returns through the read FIFO is routed back to the requester that issued it.

---
 rtl/rmc_req_arbiter_pkg.sv | 19 +
 rtl/rmc_tag_fifo.sv | 57 +++++
 rtl/rmc_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rmc_req_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmc_req_arbiter_pkg.sv
// rmc_req_arbiter_pkg
//   Shared constants and types for the remote-memory-controller request
//   arbiter and its tag queue.
//   - CPU_DATA_WIDTH    : width of a CPU request/response word
//   - RMC_ARB_NUM_REQ   : default number of host requesters
//   - RMC_ARB_TAG_DEPTH : default depth of the in-order tag queue
//   - RspState          : response-side FSM states
package rmc_req_arbiter_pkg;

  localparam int CPU_DATA_WIDTH    = 32;
  localparam int RMC_ARB_NUM_REQ   = 4;
  localparam int RMC_ARB_TAG_DEPTH = 8;

  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_HOLD = 1'b1
  } RspState;

endpackage

// File: rtl/rmc_tag_fifo.sv
// rmc_tag_fifo
//   Synchronous in-order FIFO of requester tags. The head entry is visible
//   without popping (show-ahead).
//   Ports:
//     clk, rstn    : clock, asynchronous active-low reset
//     push_i       : write push_tag_i (ignored while full)
//     push_tag_i   : tag to enqueue
//     pop_i        : drop head entry (ignored while empty)
//     head_o       : oldest tag
//     count_o      : number of stored tags (0..DEPTH)
//     full_o       : queue holds DEPTH tags
module rmc_tag_fifo #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PTR_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] head_o,
  output logic [PTR_W-1:0] count_o,
  output logic             full_o
);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_o != '0);
  assign head_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_tag_i;
  end

endmodule

// File: rtl/rmc_req_arbiter.sv
// rmc_req_arbiter
//   Shares the CPU remote-memory-controller request/response channel between
//   NUM_REQ host requesters. Requests are granted round-robin into the CPU
//   request FIFO; the requester index of every request that expects a reply
//   is queued so each returned word is routed back to its originator.
//   Optional build macro: RMC_ARB_STATS_EN adds grant_cnt_o, one saturating
//   16-bit handshake counter per requester.
//   Ports:
//     clk, rstn          : clock, asynchronous active-low reset
//     cpu_halt_i         : blocks new grants
//     req_valid_i/rsp_i/data_i : per-requester request valid, reply flag, word
//     req_ready_o        : one-hot grant
//     req_fifo_*         : CPU request FIFO write side
//     rsp_fifo_*         : CPU read FIFO (show-ahead) read side
//     rsp_valid_o/data_o : one-hot response valid, shared response word
//     rsp_ready_i        : per-requester response accept
//     rsp_orphan_o       : pulse when a word arrives with no pending tag
//     grant_cnt_o        : per-requester grant counters (RMC_ARB_STATS_EN)
module rmc_req_arbiter
  import rmc_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = RMC_ARB_NUM_REQ,
  parameter int DATA_W    = CPU_DATA_WIDTH,
  parameter int TAG_DEPTH = RMC_ARB_TAG_DEPTH,
  localparam int TAG_W    = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cpu_halt_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_rsp_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [DATA_W-1:0]              req_fifo_data_o,
  output logic                           req_fifo_wrreq_o,
  input  logic                           req_fifo_wrfull_i,
  input  logic [DATA_W-1:0]              rsp_fifo_data_i,
  input  logic                           rsp_fifo_rdempty_i,
  output logic                           rsp_fifo_rdreq_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_W-1:0]              rsp_data_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
`ifdef RMC_ARB_STATS_EN
  output logic [NUM_REQ-1:0][15:0]       grant_cnt_o,
`endif
  output logic                           rsp_orphan_o
);

  logic [TAG_W-1:0]   last_grant_q;
  logic [TAG_W-1:0]   gnt_idx;
  logic [TAG_W-1:0]   cand;
  logic               gnt_found;
  logic               grant_en;
  logic               handshake;
  logic               tag_push;
  logic               tag_pop;
  logic [TAG_W-1:0]   tag_head;
  logic [CNT_W-1:0]   tag_count;
  logic               tag_full;
  RspState            state_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [TAG_W-1:0]   rsp_tag_q;

  // Registered tag count gates grants, so a pop in the same cycle never frees
  // a slot early. rstn is included so nothing is granted while in reset.
  assign grant_en  = rstn && !cpu_halt_i && !req_fifo_wrfull_i && !tag_full;
  assign handshake = gnt_found && grant_en;
  assign tag_push  = handshake && req_rsp_i[gnt_idx];

  // Round-robin search starting just above the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = TAG_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (handshake) req_ready_o[gnt_idx] = 1'b1;
  end

  assign req_fifo_wrreq_o = handshake;
  assign req_fifo_data_o  = handshake ? req_data_i[gnt_idx] : '0;

  // Reset value NUM_REQ-1 gives requester 0 first priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          last_grant_q <= TAG_W'(NUM_REQ - 1);
    else if (handshake) last_grant_q <= gnt_idx;
  end

  rmc_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (tag_push),
    .push_tag_i (gnt_idx),
    .pop_i      (tag_pop),
    .head_o     (tag_head),
    .count_o    (tag_count),
    .full_o     (tag_full)
  );

  // The read FIFO is popped as soon as a word is seen in RSP_IDLE; with no
  // pending tag the word is thrown away and flagged as an orphan.
  assign rsp_fifo_rdreq_o = rstn && (state_q == RSP_IDLE) && !rsp_fifo_rdempty_i;
  assign rsp_orphan_o     = rsp_fifo_rdreq_o && (tag_count == '0);
  assign tag_pop          = (state_q == RSP_HOLD) && rsp_ready_i[rsp_tag_q];
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;

  // Response FSM: capture word and head tag, hold until that requester accepts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RSP_IDLE;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      case (state_q)
        RSP_IDLE: begin
          if (!rsp_fifo_rdempty_i && (tag_count != '0)) begin
            rsp_data_q  <= rsp_fifo_data_i;
            rsp_tag_q   <= tag_head;
            rsp_valid_q <= NUM_REQ'(1) << tag_head;
            state_q     <= RSP_HOLD;
          end
        end
        RSP_HOLD: begin
          if (rsp_ready_i[rsp_tag_q]) begin
            rsp_valid_q <= '0;
            state_q     <= RSP_IDLE;
          end
        end
        default: state_q <= RSP_IDLE;
      endcase
    end
  end

`ifdef RMC_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q;

  // Per-requester handshake counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_ready_o[r] && (grant_cnt_q[r] != 16'hFFFF))
          grant_cnt_q[r] <= grant_cnt_q[r] + 16'd1;
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_rmc_req_arbiter.sv
// tb_rmc_req_arbiter
//   Directed scoreboard bench for rmc_req_arbiter (4 requesters, 32-bit
//   words, 8 tags). Expected grants, responses and orphan pulses are queued
//   when stimulus is issued; a monitor pops and compares whenever the DUT
//   presents them. A small show-ahead read FIFO model feeds responses.
module tb_rmc_req_arbiter;
  import rmc_req_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TD = 8;

  typedef struct packed {
    logic [NR-1:0] oneHot;
    logic [DW-1:0] data;
  } ExpEntry;

  logic                   clk;
  logic                   rstn;
  logic                   cpuHalt;
  logic [NR-1:0]          reqValid;
  logic [NR-1:0]          reqRsp;
  logic [NR-1:0][DW-1:0]  reqData;
  logic [NR-1:0]          req_ready_o;
  logic [DW-1:0]          req_fifo_data_o;
  logic                   req_fifo_wrreq_o;
  logic                   reqFifoWrfull;
  logic [DW-1:0]          rspFifoData;
  logic                   rspFifoRdempty;
  logic                   rsp_fifo_rdreq_o;
  logic [NR-1:0]          rsp_valid_o;
  logic [DW-1:0]          rsp_data_o;
  logic [NR-1:0]          rspReady;
  logic                   rsp_orphan_o;
`ifdef RMC_ARB_STATS_EN
  logic [NR-1:0][15:0]    grantCnt;
`endif

  int checks = 0;
  int errors = 0;
  ExpEntry expReqQ[$];
  ExpEntry expRspQ[$];
  int orphansExpected = 0;
  logic [DW-1:0] rdFifo[$];
  logic popPending = 1'b0;
  logic [NR-1:0] rspPrev = '0;

  rmc_req_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .TAG_DEPTH (TD)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .cpu_halt_i         (cpuHalt),
    .req_valid_i        (reqValid),
    .req_rsp_i          (reqRsp),
    .req_data_i         (reqData),
    .req_ready_o        (req_ready_o),
    .req_fifo_data_o    (req_fifo_data_o),
    .req_fifo_wrreq_o   (req_fifo_wrreq_o),
    .req_fifo_wrfull_i  (reqFifoWrfull),
    .rsp_fifo_data_i    (rspFifoData),
    .rsp_fifo_rdempty_i (rspFifoRdempty),
    .rsp_fifo_rdreq_o   (rsp_fifo_rdreq_o),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_data_o         (rsp_data_o),
    .rsp_ready_i        (rspReady),
`ifdef RMC_ARB_STATS_EN
    .grant_cnt_o        (grantCnt),
`endif
    .rsp_orphan_o       (rsp_orphan_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic updateRdFifo();
    rspFifoRdempty = (rdFifo.size() == 0);
    rspFifoData    = (rdFifo.size() == 0) ? '0 : rdFifo[0];
  endtask

  task automatic pushRsp(input logic [DW-1:0] word);
    rdFifo.push_back(word);
    updateRdFifo();
  endtask

  task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR-1:0] rsp);
    reqValid = valid;
    reqRsp   = rsp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (expRspQ.size() == 0 && rsp_valid_o == '0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  // Read FIFO model: pops one cycle-slot after the DUT strobes rdreq.
  always @(negedge clk) popPending = rsp_fifo_rdreq_o;

  always @(posedge clk) begin
    #1;
    if (popPending && rdFifo.size() > 0) void'(rdFifo.pop_front());
    popPending = 1'b0;
    updateRdFifo();
  end

  // Monitor: compares every grant, every new response and every orphan pulse.
  always @(negedge clk) begin
    ExpEntry e;
    if (req_fifo_wrreq_o) begin
      if (expReqQ.size() == 0) begin
        checkOutput("unexpected grant", 32'(req_ready_o), 32'h0);
      end else begin
        e = expReqQ.pop_front();
        checkOutput("grant onehot", 32'(req_ready_o), 32'(e.oneHot));
        checkOutput("grant data", req_fifo_data_o, e.data);
      end
    end
    if (rsp_valid_o != '0 && rspPrev == '0) begin
      if (expRspQ.size() == 0) begin
        checkOutput("unexpected response", 32'(rsp_valid_o), 32'h0);
      end else begin
        e = expRspQ.pop_front();
        checkOutput("rsp onehot", 32'(rsp_valid_o), 32'(e.oneHot));
        checkOutput("rsp data", rsp_data_o, e.data);
      end
    end
    rspPrev = rsp_valid_o;
    if (rsp_orphan_o) begin
      if (orphansExpected == 0) begin
        checkOutput("unexpected orphan", 32'(rsp_orphan_o), 32'h0);
      end else begin
        orphansExpected--;
        checkOutput("orphan rsp_valid", 32'(rsp_valid_o), 32'h0);
      end
    end
  end

  // Watchdog: guarantees termination even if the DUT wedges a wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    logic got;
    rstn = 1'b0;
    cpuHalt = 1'b0;
    reqFifoWrfull = 1'b0;
    rspReady = '0;
    reqData = '0;
    applyStimulus('0, '0);
    updateRdFifo();

    // Reset state.
    #12;
    checkOutput("reset req_ready", 32'(req_ready_o), 32'h0);
    checkOutput("reset wrreq", 32'(req_fifo_wrreq_o), 32'h0);
    checkOutput("reset req data", req_fifo_data_o, 32'h0);
    checkOutput("reset rdreq", 32'(rsp_fifo_rdreq_o), 32'h0);
    checkOutput("reset rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("reset rsp_data", rsp_data_o, 32'h0);
    checkOutput("reset orphan", 32'(rsp_orphan_o), 32'h0);
    tick();
    rstn = 1'b1;
    tick();

    // Round robin: all valid, no replies -> grants 0,1,2,3,0.
    for (int i = 0; i < NR; i++) reqData[i] = 32'h100 + 32'(i);
    expReqQ.push_back('{4'b0001, 32'h100});
    expReqQ.push_back('{4'b0010, 32'h101});
    expReqQ.push_back('{4'b0100, 32'h102});
    expReqQ.push_back('{4'b1000, 32'h103});
    expReqQ.push_back('{4'b0001, 32'h100});
    applyStimulus(4'b1111, 4'b0000);
    repeat (5) tick();
    applyStimulus('0, '0);
    tick();

    // Requester 2 request with reply; reply arrives later.
    reqData[2] = 32'hA5;
    expReqQ.push_back('{4'b0100, 32'hA5});
    applyStimulus(4'b0100, 4'b0100);
    tick();
    applyStimulus('0, '0);
    rspReady = 4'b0100;
    tick();
    tick();
    expRspQ.push_back('{4'b0100, 32'h5A});
    pushRsp(32'h5A);
    @(negedge clk);
    checkOutput("rdreq on word", 32'(rsp_fifo_rdreq_o), 32'h1);
    checkOutput("valid not before latency", 32'(rsp_valid_o), 32'h0);
    tick();
    @(negedge clk);
    checkOutput("rsp_valid one cycle later", 32'(rsp_valid_o), 32'h4);
    checkOutput("rsp_data 5A", rsp_data_o, 32'h5A);
    tick();
    @(negedge clk);
    checkOutput("rsp_valid after accept", 32'(rsp_valid_o), 32'h0);
    tick();

    // Requesters 1 then 3; only requester 3 ready at first.
    reqData[1] = 32'h11;
    expReqQ.push_back('{4'b0010, 32'h11});
    applyStimulus(4'b0010, 4'b0010);
    tick();
    reqData[3] = 32'h33;
    expReqQ.push_back('{4'b1000, 32'h33});
    applyStimulus(4'b1000, 4'b1000);
    tick();
    applyStimulus('0, '0);
    rspReady = 4'b1000;
    expRspQ.push_back('{4'b0010, 32'h1111});
    expRspQ.push_back('{4'b1000, 32'h3333});
    pushRsp(32'h1111);
    pushRsp(32'h3333);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      checkOutput("in-order hold for 1", 32'(rsp_valid_o), 32'h2);
    end
    tick();
    rspReady = 4'b1010;
    waitDrain("drain 1 then 3", 20);
    rspReady = '0;

    // Fill all 8 tags from requester 0, then the 9th must wait.
    applyStimulus(4'b0001, 4'b0001);
    for (int k = 0; k < TD; k++) begin
      reqData[0] = 32'h200 + 32'(k);
      expReqQ.push_back('{4'b0001, 32'h200 + 32'(k)});
      tick();
    end
    reqData[0] = 32'h2FF;
    applyStimulus(4'b0001, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("tag full blocks", 32'(req_ready_o), 32'h0);
      tick();
    end
    expReqQ.push_back('{4'b0001, 32'h2FF});
    expRspQ.push_back('{4'b0001, 32'h900});
    rspReady = 4'b0001;
    pushRsp(32'h900);
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_fifo_wrreq_o) begin
        got = 1'b1;
        waited = i;
        break;
      end
      tick();
    end
    checkOutput("9th granted", 32'(got), 32'h1);
    checkOutput("9th grant after accept", 32'(waited), 32'd2);
    tick();
    applyStimulus('0, '0);
    for (int k = 0; k < TD - 1; k++) begin
      expRspQ.push_back('{4'b0001, 32'h910 + 32'(k)});
      pushRsp(32'h910 + 32'(k));
    end
    waitDrain("drain 7 tags", 40);

    // Request FIFO full and CPU halt both block grants.
    reqFifoWrfull = 1'b1;
    applyStimulus(4'b1111, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("wrfull blocks", 32'(req_ready_o), 32'h0);
      tick();
    end
    reqFifoWrfull = 1'b0;
    cpuHalt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("halt blocks", 32'(req_fifo_wrreq_o), 32'h0);
      tick();
    end
    applyStimulus('0, '0);
    cpuHalt = 1'b0;
    tick();

    // Orphan word with empty tag queue.
    orphansExpected++;
    pushRsp(32'hDEAD);
    @(negedge clk);
    checkOutput("orphan rdreq", 32'(rsp_fifo_rdreq_o), 32'h1);
    checkOutput("orphan pulse", 32'(rsp_orphan_o), 32'h1);
    tick();
    @(negedge clk);
    checkOutput("orphan one cycle", 32'(rsp_orphan_o), 32'h0);
    checkOutput("orphan no valid", 32'(rsp_valid_o), 32'h0);
    tick();

    // Reset while holding a response.
    reqData[1] = 32'h1234;
    expReqQ.push_back('{4'b0010, 32'h1234});
    applyStimulus(4'b0010, 4'b0010);
    tick();
    applyStimulus('0, '0);
    rspReady = '0;
    expRspQ.push_back('{4'b0010, 32'h77});
    pushRsp(32'h77);
    tick();
    @(negedge clk);
    checkOutput("hold before reset", 32'(rsp_valid_o), 32'h2);
    #1;
    applyStimulus(4'b1111, 4'b0000);
    rstn = 1'b0;
    #1;
    checkOutput("async reset rsp_valid", 32'(rsp_valid_o), 32'h0);
    checkOutput("async reset rsp_data", rsp_data_o, 32'h0);
    checkOutput("async reset req_ready", 32'(req_ready_o), 32'h0);
    checkOutput("async reset wrreq", 32'(req_fifo_wrreq_o), 32'h0);
    rdFifo.delete();
    updateRdFifo();
    tick();
    tick();
    reqData[0] = 32'hC0;
    expReqQ.push_back('{4'b0001, 32'hC0});
    rstn = 1'b1;
    tick();
    applyStimulus('0, '0);
    repeat (3) tick();

    checkOutput("request queue empty", 32'(expReqQ.size()), 32'd0);
    checkOutput("response queue empty", 32'(expRspQ.size()), 32'd0);
    checkOutput("orphans consumed", 32'(orphansExpected), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
